// File: rtl/led_status_ctrl.sv
// led_status_ctrl
//   Miner status-LED controller. Converts single-cycle miner events and the
//   hashing level into timed LED patterns: a work pattern (odd LEDs), a
//   hashing chaser (one-hot walking over led[NUM_LEDS-1:1]) and a held
//   result-count display. led[0] mirrors rst combinationally.
//
//   Optional feature macro: LED_HEARTBEAT_EN
//     defined   -> in IDLE, led[NUM_LEDS-1] toggles every HEARTBEAT_CYCLES
//     undefined -> no heartbeat counter; led[NUM_LEDS-1] stays 0 in IDLE
//
// Ports
//   clk          in   1         system clock
//   rst          in   1         asynchronous, active-high reset
//   new_work     in   1         1-cycle pulse: work received
//   new_work_88  in   1         1-cycle pulse: 88-byte work received
//   new_result   in   1         1-cycle pulse: share/result found
//   hashing      in   1         level: core is hashing
//   led          out  NUM_LEDS  LED drive, active-high
//   state        out  2         current FSM state (debug)
module led_status_ctrl #(
  parameter int NUM_LEDS         = 8,
  parameter int WORK_HOLD        = 100000000,
  parameter int RESULT_HOLD      = 100000000,
  parameter int STEP_CYCLES      = 12500000,
  parameter int HEARTBEAT_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_work,
  input  logic                new_work_88,
  input  logic                new_result,
  input  logic                hashing,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          state
);

  localparam int HOLD_MAX = (WORK_HOLD > RESULT_HOLD) ? WORK_HOLD : RESULT_HOLD;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam int SW       = $clog2(STEP_CYCLES + 1);
  localparam int PW       = $clog2(NUM_LEDS);
  localparam int unsigned CW = NUM_LEDS - 1;

  localparam logic [HW-1:0] WORK_LAST   = HW'(WORK_HOLD - 1);
  localparam logic [HW-1:0] RESULT_LAST = HW'(RESULT_HOLD - 1);
  localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] POS_FIRST   = PW'(1);
  localparam logic [PW-1:0] POS_LAST    = PW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WORK   = 2'd1,
    HASH   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d, hold_inc;
  logic [SW-1:0]   step_q, step_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   led_q, led_d;
  logic            hb_d;
  logic            work_evt;

  assign led   = {led_q, rst};
  assign state = state_q;

  // Next state, timers, chase position and result count.
  always_comb begin
    state_d  = state_q;
    hold_d   = '0;
    step_d   = '0;
    pos_d    = POS_FIRST;
    cnt_d    = cnt_q;
    work_evt = new_work | new_work_88;
    hold_inc = (hold_q == '1) ? hold_q : hold_q + 1'b1;

    if (new_result) begin
      state_d = RESULT;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end else if (work_evt) begin
      state_d = WORK;
    end else begin
      unique case (state_q)
        WORK: begin
          if (hold_q == WORK_LAST) state_d = hashing ? HASH : IDLE;
          else                     hold_d  = hold_inc;
        end
        RESULT: begin
          if (hold_q == RESULT_LAST) state_d = hashing ? HASH : IDLE;
          else                       hold_d  = hold_inc;
        end
        HASH: begin
          if (!hashing) state_d = IDLE;
        end
        default: begin
          if (hashing) state_d = HASH;
        end
      endcase
    end

    // Chaser only advances while staying in HASH; any entry reloads pos=1, step=0.
    if (state_q == HASH && state_d == HASH) begin
      if (step_q == STEP_LAST) begin
        step_d = '0;
        pos_d  = (pos_q == POS_LAST) ? POS_FIRST : pos_q + 1'b1;
      end else begin
        step_d = step_q + 1'b1;
        pos_d  = pos_q;
      end
    end
  end

`ifdef LED_HEARTBEAT_EN
  localparam int HBW = $clog2(HEARTBEAT_CYCLES + 1);
  localparam logic [HBW-1:0] HB_LAST = HBW'(HEARTBEAT_CYCLES - 1);

  logic [HBW-1:0] hb_cnt_q, hb_cnt_d;
  logic           hb_q;

  always_comb begin
    hb_cnt_d = '0;
    hb_d     = 1'b0;
    if (state_q == IDLE && state_d == IDLE) begin
      if (hb_cnt_q == HB_LAST) begin
        hb_cnt_d = '0;
        hb_d     = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + 1'b1;
        hb_d     = hb_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end
`else
  // No heartbeat: HEARTBEAT_CYCLES is always >= 1, so this is constant 0.
  assign hb_d = (HEARTBEAT_CYCLES < 1);
`endif

  // LEDs decode from the next state so the pattern changes on the same edge as state.
  always_comb begin
    led_d = '0;
    unique case (state_d)
      WORK: begin
        for (int unsigned i = 0; i < CW; i++) led_d[i] = (i % 2 == 0);
      end
      HASH: begin
        for (int unsigned i = 0; i < CW; i++) led_d[i] = (pos_d == PW'(i + 1));
      end
      RESULT: led_d = cnt_d;
      default: led_d[CW-1] = hb_d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      step_q  <= '0;
      pos_q   <= POS_FIRST;
      cnt_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl
//   Directed self-checking bench for led_status_ctrl with NUM_LEDS=8,
//   WORK_HOLD=10, RESULT_HOLD=6, STEP_CYCLES=4, HEARTBEAT_CYCLES=5.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_led_status_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_work = 1'b0;
  logic       new_work_88 = 1'b0;
  logic       new_result = 1'b0;
  logic       hashing = 1'b0;
  logic [7:0] led;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .NUM_LEDS(8),
    .WORK_HOLD(10),
    .RESULT_HOLD(6),
    .STEP_CYCLES(4),
    .HEARTBEAT_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .new_work(new_work),
    .new_work_88(new_work_88),
    .new_result(new_result),
    .hashing(hashing),
    .led(led),
    .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1: reset behaviour
    tick(2);
    check("rst_led", 32'(led), 32'h01);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    tick(1);
    check("post_rst_led", 32'(led), 32'h00);
    check("post_rst_state", 32'(state), 32'd0);

    // 2: new_work, no hashing -> WORK for 10 cycles, then IDLE
    new_work = 1'b1; tick(1); new_work = 1'b0;
    check("work_led", 32'(led), 32'hAA);
    check("work_state", 32'(state), 32'd1);
    tick(9);
    check("work_last_led", 32'(led), 32'hAA);
    tick(1);
    check("work_exp_led", 32'(led), 32'h00);
    check("work_exp_state", 32'(state), 32'd0);

    // 2b: new_work_88 gives the same response
    new_work_88 = 1'b1; tick(1); new_work_88 = 1'b0;
    check("w88_led", 32'(led), 32'hAA);
    check("w88_state", 32'(state), 32'd1);
    tick(9);
    check("w88_last_state", 32'(state), 32'd1);
    tick(1);
    check("w88_exp_led", 32'(led), 32'h00);

    // 3: restart of hold by a second new_work; hashing at expiry -> HASH
    new_work = 1'b1; tick(1); new_work = 1'b0;
    tick(4);
    new_work = 1'b1; tick(1); new_work = 1'b0;
    hashing = 1'b1;
    tick(9);
    check("restart_still_work", 32'(state), 32'd1);
    check("restart_still_led", 32'(led), 32'hAA);
    tick(1);
    check("restart_to_hash_state", 32'(state), 32'd2);
    check("restart_to_hash_led", 32'(led), 32'h02);
    hashing = 1'b0;
    tick(1);
    check("hash_drop_state", 32'(state), 32'd0);

    // 4: chaser from IDLE
    hashing = 1'b1;
    tick(1);
    check("chase_entry", 32'(led), 32'h02);
    tick(3);
    check("chase_hold3", 32'(led), 32'h02);
    tick(1);
    check("chase_pos2", 32'(led), 32'h04);
    for (int k = 3; k <= 7; k++) begin
      tick(4);
      check($sformatf("chase_pos%0d", k), 32'(led), 32'h1 << k);
    end
    tick(4);
    check("chase_wrap", 32'(led), 32'h02);
    hashing = 1'b0;
    tick(1);
    check("chase_drop_led", 32'(led), 32'h00);
    check("chase_drop_state", 32'(state), 32'd0);

    // 1b: async reset mid-HASH
    hashing = 1'b1;
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'h01);
    check("async_rst_state", 32'(state), 32'd0);
    tick(2);
    hashing = 1'b0;
    rst = 1'b0;
    tick(1);
    check("async_rel_state", 32'(state), 32'd0);
    check("async_rel_led", 32'(led), 32'h00);

    // 5: new_result beats new_work; RESULT held 6 cycles
    new_result = 1'b1; new_work = 1'b1; tick(1);
    new_result = 1'b0; new_work = 1'b0;
    check("res_state", 32'(state), 32'd3);
    check("res_led", 32'(led), 32'h02);
    tick(5);
    check("res_last_led", 32'(led), 32'h02);
    tick(1);
    check("res_exp_state", 32'(state), 32'd0);
    check("res_exp_led", 32'(led), 32'h00);

    // 5b: 200 results -> saturation at 127
    new_result = 1'b1;
    tick(5);
    check("res_cnt6", 32'(led), 32'h0C);
    tick(195);
    new_result = 1'b0;
    check("res_sat", 32'(led), 32'hFE);
    new_result = 1'b1; tick(1); new_result = 1'b0;
    check("res_sat_hold", 32'(led), 32'hFE);
    // new work aborts RESULT
    new_work = 1'b1; tick(1); new_work = 1'b0;
    check("abort_res_state", 32'(state), 32'd1);
    check("abort_res_led", 32'(led), 32'hAA);
    tick(10);
    check("idle_again_state", 32'(state), 32'd0);

    // 6: idle heartbeat
`ifdef LED_HEARTBEAT_EN
    check("hb_start", 32'(led), 32'h00);
    tick(4);
    check("hb_before", 32'(led), 32'h00);
    tick(1);
    check("hb_on", 32'(led), 32'h80);
    tick(4);
    check("hb_on_hold", 32'(led), 32'h80);
    tick(1);
    check("hb_off", 32'(led), 32'h00);
`else
    check("idle_start", 32'(led), 32'h00);
    tick(5);
    check("idle_5", 32'(led), 32'h00);
    tick(5);
    check("idle_10", 32'(led), 32'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
